// File: rtl/byte_word_packer_pkg.sv
// Shared widths, byte-count encodings and lane helpers for the byte-to-word packer.
package byte_word_packer_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int CNT_W  = 2;
    localparam int BCNT_W = 3;

    localparam logic [BCNT_W-1:0] BYTES_1 = 3'd1;
    localparam logic [BCNT_W-1:0] BYTES_2 = 3'd2;
    localparam logic [BCNT_W-1:0] BYTES_3 = 3'd3;
    localparam logic [BCNT_W-1:0] BYTES_4 = 3'd4;

    // Lane 0 is the most significant byte, so the first byte received lands in [31:24].
    function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] w,
                                                   input logic [CNT_W-1:0]  lane,
                                                   input logic [BYTE_W-1:0] b);
        logic [WORD_W-1:0] r;
        r = w;
        case (lane)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            2'd3:    r[7:0]   = b;
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [BCNT_W-1:0] bytes_after(input logic [CNT_W-1:0] cnt);
        logic [BCNT_W-1:0] r;
        case (cnt)
            2'd0:    r = BYTES_1;
            2'd1:    r = BYTES_2;
            2'd2:    r = BYTES_3;
            2'd3:    r = BYTES_4;
            default: r = BYTES_4;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/byte_word_packer_sync_fifo.sv
// Synchronous FIFO with an explicit occupancy counter and combinational head read.
module sync_fifo #(
    parameter int W  = 35,
    parameter int AW = 2
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem_q [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          wr_en_s, rd_en_s;

    assign full_o  = (level_q == DEPTH);
    assign empty_o = (level_q == {(AW+1){1'b0}});
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign rd_en_s = pop_i & ~empty_o;
    assign wr_en_s = push_i & (~full_o | rd_en_s);

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   level_d = level_q + {{AW{1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{AW{1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge sclk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// Packs a valid-strobed byte stream big-endian into 32-bit words, with flush,
// FIFO buffering, valid/ready output and a sticky overflow flag.
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic                sclk,
    input  logic                rst_n,
    input  logic                i_dv,
    input  logic [BYTE_W-1:0]   i_data,
    input  logic                i_flush,
    input  logic                i_ready,
    input  logic                i_clr_ovf,
    output logic                o_valid,
    output logic [WORD_W-1:0]   o_word,
    output logic [BCNT_W-1:0]   o_bytes,
    output logic [AW:0]         o_level,
    output logic                o_overflow
);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [WORD_W-1:0]        sr_q, sr_d;
    logic                     ovf_q, ovf_d;
    logic [WORD_W-1:0]        ins_s;
    logic                     push_s, pop_s, full_s, empty_s;
    logic [WORD_W-1:0]        push_word_s;
    logic [BCNT_W-1:0]        push_bytes_s;
    logic [WORD_W+BCNT_W-1:0] head_s;

    // Shift register with the incoming byte placed at the current lane; unused lanes stay zero.
    assign ins_s = put_lane(sr_q, cnt_q, i_data);

    // Packing, wrap and flush decisions.
    always_comb begin
        push_s       = 1'b0;
        push_word_s  = sr_q;
        push_bytes_s = BYTES_4;
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        if (i_flush) begin
            cnt_d = 2'd0;
            sr_d  = {WORD_W{1'b0}};
            if (i_dv) begin
                push_s       = 1'b1;
                push_word_s  = ins_s;
                push_bytes_s = bytes_after(cnt_q);
            end else if (cnt_q != 2'd0) begin
                push_s       = 1'b1;
                push_word_s  = sr_q;
                push_bytes_s = {1'b0, cnt_q};
            end else begin
                push_s = 1'b0;
            end
        end else if (i_dv) begin
            if (cnt_q == 2'd3) begin
                push_s       = 1'b1;
                push_word_s  = ins_s;
                push_bytes_s = BYTES_4;
                cnt_d        = 2'd0;
                sr_d         = {WORD_W{1'b0}};
            end else begin
                sr_d  = ins_s;
                cnt_d = cnt_q + 2'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign pop_s = ~empty_s & i_ready;

    // A dropped word sets the flag; setting wins over a same-edge clear.
    always_comb begin
        ovf_d = ovf_q;
        if (push_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Packing state and overflow flag.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            sr_q  <= {WORD_W{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
            ovf_q <= ovf_d;
        end
    end

    sync_fifo #(
        .W  (WORD_W + BCNT_W),
        .AW (AW)
    ) u_fifo (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({push_bytes_s, push_word_s}),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (o_level)
    );

    assign o_valid    = ~empty_s;
    assign o_word     = head_s[WORD_W-1:0];
    assign o_bytes    = head_s[WORD_W+BCNT_W-1:WORD_W];
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed self-checking bench for byte_word_packer (AW=2, depth 4).
module tb_byte_word_packer;

    logic        sclk;
    logic        rst_n;
    logic        i_dv;
    logic [7:0]  i_data;
    logic        i_flush;
    logic        i_ready;
    logic        i_clr_ovf;
    logic        o_valid;
    logic [31:0] o_word;
    logic [2:0]  o_bytes;
    logic [2:0]  o_level;
    logic        o_overflow;

    int total = 0;
    int bad   = 0;

    byte_word_packer #(.AW(2)) dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .i_dv       (i_dv),
        .i_data     (i_data),
        .i_flush    (i_flush),
        .i_ready    (i_ready),
        .i_clr_ovf  (i_clr_ovf),
        .o_valid    (o_valid),
        .o_word     (o_word),
        .o_bytes    (o_bytes),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic fl);
        i_dv    = 1'b1;
        i_data  = b;
        i_flush = fl;
        tick();
        i_dv    = 1'b0;
        i_flush = 1'b0;
        i_data  = 8'h00;
    endtask

    function automatic logic [31:0] wk(input int k);
        logic [7:0] base;
        base = 8'(16 * k);
        return {base, base + 8'd1, base + 8'd2, base + 8'd3};
    endfunction

    initial begin
        logic [31:0] q [$];
        logic [31:0] w;
        rst_n = 1'b0; i_dv = 1'b0; i_data = 8'h00; i_flush = 1'b0;
        i_ready = 1'b0; i_clr_ovf = 1'b0;
        #12;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_level", 64'(o_level), 64'd0);
        check("rst_ovf", 64'(o_overflow), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: generator pattern, ready high
        i_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            i_dv   = ((c % 8) == 0) || ((c % 8) == 2);
            i_data = ((c % 8) == 0) ? 8'h07 : 8'h05;
            tick();
            check($sformatf("gen_valid_c%0d", c), 64'(o_valid), (c == 10) ? 64'd1 : 64'd0);
            if (c == 10) begin
                check("gen_word", 64'(o_word), 64'h07050705);
                check("gen_bytes", 64'(o_bytes), 64'd4);
            end
        end
        i_dv = 1'b0; i_data = 8'h00;
        i_ready = 1'b0;

        // 2: three bytes then lone flush; second lone flush is a no-op
        send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b0);
        check("fl3_pre_level", 64'(o_level), 64'd0);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        check("fl3_valid", 64'(o_valid), 64'd1);
        check("fl3_word", 64'(o_word), 64'hA1B2C300);
        check("fl3_bytes", 64'(o_bytes), 64'd3);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        check("fl_empty_level", 64'(o_level), 64'd1);
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        check("fl3_drained", 64'(o_level), 64'd0);

        // 3: flush together with the last byte
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
        check("fldv_word", 64'(o_word), 64'h11223300);
        check("fldv_bytes", 64'(o_bytes), 64'd3);
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b1);
        check("fldv4_word", 64'(o_word), 64'h44556677);
        check("fldv4_bytes", 64'(o_bytes), 64'd4);
        i_flush = 1'b1; tick(); i_flush = 1'b0;
        check("fldv4_cnt0", 64'(o_level), 64'd1);
        i_ready = 1'b1; tick(); i_ready = 1'b0;
        check("fldv4_drained", 64'(o_level), 64'd0);

        // 4: fill, overflow, clear racing a set, clear alone
        for (int k = 0; k < 5; k++) begin
            w = wk(k);
            send(w[31:24], 1'b0); send(w[23:16], 1'b0); send(w[15:8], 1'b0); send(w[7:0], 1'b0);
            if (k == 3) check("full_ovf_clean", 64'(o_overflow), 64'd0);
        end
        check("full_level", 64'(o_level), 64'd4);
        check("ovf_set", 64'(o_overflow), 64'd1);
        w = wk(5);
        send(w[31:24], 1'b0); send(w[23:16], 1'b0); send(w[15:8], 1'b0);
        i_clr_ovf = 1'b1; send(w[7:0], 1'b0); i_clr_ovf = 1'b0;
        check("ovf_set_wins", 64'(o_overflow), 64'd1);
        i_clr_ovf = 1'b1; tick(); i_clr_ovf = 1'b0;
        check("ovf_clr", 64'(o_overflow), 64'd0);

        // 5: push and pop on the same edge while full, then drain in order
        w = wk(6);
        send(w[31:24], 1'b0); send(w[23:16], 1'b0); send(w[15:8], 1'b0);
        i_ready = 1'b1; send(w[7:0], 1'b0); i_ready = 1'b0;
        check("pp_level", 64'(o_level), 64'd4);
        check("pp_ovf", 64'(o_overflow), 64'd0);
        q = '{wk(1), wk(2), wk(3), wk(6)};
        tick();
        check("hold_word", 64'(o_word), 64'(q[0]));
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_word%0d", i), 64'(o_word), 64'(q[i]));
            check($sformatf("drain_bytes%0d", i), 64'(o_bytes), 64'd4);
            tick();
        end
        i_ready = 1'b0;
        check("drain_valid", 64'(o_valid), 64'd0);
        check("drain_level", 64'(o_level), 64'd0);

        // 6: asynchronous reset mid-word with two words queued
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b0);
        send(8'h09, 1'b0); send(8'h0A, 1'b0);
        check("pre_rst_level", 64'(o_level), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_level", 64'(o_level), 64'd0);
        @(negedge sclk);
        rst_n = 1'b1;
        tick();
        send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b0);
        check("post_rst_valid", 64'(o_valid), 64'd1);
        check("post_rst_word", 64'(o_word), 64'hDEADBEEF);
        check("post_rst_level", 64'(o_level), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
Downstream consumer of the 8-bit valid-strobed byte stream (o_dv/o_data) produced by the counter-driven pattern generator.
- Packs accepted bytes big-endian into 32-bit words.
- Buffers the words in a small synchronous FIFO.
- Presents them on a valid/ready output interface.
- Supports flushing a partial word and reports FIFO overflow with a sticky flag.

Parameters:
AW, 2, FIFO address width; depth = 2**AW entries (AW >= 1).

Ports:
sclk  input  1  clock, all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
i_dv  input  1  input byte valid; byte accepted on every edge where high (no backpressure upstream).
i_data  input  8  input byte.
i_flush  input  1  emit the current partial word.
i_ready  input  1  downstream ready.
o_valid  output  1  FIFO non-empty.
o_word  output  32  head word; first byte in [31:24].
o_bytes  output  3  valid byte count of head word, 1..4; unused low bytes are zero.
o_level  output  AW+1  FIFO occupancy, 0..2**AW.
o_overflow  output  1  sticky: a word was dropped because the FIFO was full.
i_clr_ovf  input  1  clears o_overflow.

Behaviour:
- Reset (rst_n=0, async): byte count cnt=0, shift register=0, FIFO pointers=0, o_level=0, o_valid=0, o_overflow=0. o_word/o_bytes are don't-care while o_valid=0.
- Packing:
  - cnt is 2 bits, 0..3. On an edge with i_dv=1 and i_flush=0: if cnt<3, the byte is stored at lane cnt (lane 0 = [31:24]) and cnt increments.
  - If cnt==3, a push of {lanes0..2, i_data} with bytes=4 is issued on that same edge, and cnt returns to 0 (wrap).
- Flush (i_flush=1 on an edge):
  - With i_dv=1, the byte is first included at lane cnt. The push carries cnt+1 bytes (4 if cnt==3). Remaining lanes are zero.
  - With i_dv=0 and cnt>0: push of cnt bytes, zero-padded.
  - With i_dv=0 and cnt==0: no-op.
  - After any flush, cnt=0 and the shift register is cleared.
- Push/pop:
  - pop = o_valid & i_ready.
  - A push is written on the same edge it is issued. o_valid rises the cycle after the edge (one-cycle latency from the last byte to o_valid when the FIFO is empty).
  - o_word/o_bytes are a combinational read of the head entry and are stable while o_valid=1 and i_ready=0.
- Full:
  - A push when o_level==2**AW with no pop on the same edge drops the word, sets o_overflow, and still resets cnt.
  - A push and pop on the same edge when full both succeed; level is unchanged.
- Empty: i_ready with o_valid=0 has no effect. Push and pop on the same edge when empty cannot occur, because pop requires o_valid.
- o_level: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo 2**AW.
- Overflow flag: set has priority over i_clr_ovf on the same edge.
- Reset mid-word or mid-transfer discards the partial word and all FIFO contents immediately.

Decomposition:
- Shared package holds WORD_W=32, BYTE_W=8, LANES=4, and the bytes-count encoding constants (BYTES_1..BYTES_4).
- One sub-module, sync_fifo, is natural. It is parameterised by width (WORD_W+3) and AW and provides push, pop, full, empty, level and a combinational head output.
- Packing and flush logic stays in byte_word_packer.

Test Plan:
1. Reset, then feed the generator pattern (dv bytes 7 at count 0 and 5 at count 2, every 8 cycles) for 16 cycles with i_ready=1 -> one word 0x07050705, o_bytes=4; o_valid pulses for 1 cycle, 1 cycle after the 4th byte.
2. Bytes 0xA1,0xB2,0xC3, then i_flush alone -> word 0xA1B2C300, o_bytes=3; a following lone i_flush gives no push.
3. Bytes 0x11,0x22, then 0x33 with i_flush in the same cycle -> word 0x11223300, o_bytes=3. Repeat with cnt==3 -> o_bytes=4 and cnt=0.
4. Hold i_ready=0 with AW=2 and push 5 full words -> o_level=4, 5th word dropped, o_overflow=1. Then pulse i_clr_ovf together with a 6th full-FIFO push -> o_overflow stays 1. Clear alone -> 0.
5. FIFO full; on the cycle the next word completes, assert i_ready=1 -> first word popped, new word stored, o_level stays 4, no overflow. Drain and check order.
6. Assert rst_n=0 asynchronously mid-word with 2 words queued -> o_valid=0 and o_level=0 immediately. After release, feed 4 bytes -> the word contains only post-reset bytes.
